// File: rtl/pixel_compositor_pkg.sv
// Shared constants, codes, palette and bus types for the pixel compositor.
package pixel_compositor_pkg;

  localparam int unsigned tile_size                   = 16;
  localparam int unsigned CONGRATULATIONS_MASK_WIDTH  = 64;
  localparam int unsigned CONGRATULATIONS_MASK_HEIGHT = 16;
  localparam int unsigned COORD_W                     = 10;
  // One extra bit so that a negative difference reads as a large unsigned value.
  localparam int unsigned DIFF_W                      = COORD_W + 1;

  typedef enum logic [1:0] {
    TILE_EMPTY   = 2'd0,
    TILE_WALL    = 2'd1,
    TILE_DOT     = 2'd2,
    TILE_BIG_DOT = 2'd3
  } tile_type_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_WHITE  = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t RGB_EYE    = '{r: 4'h2, g: 4'h2, b: 4'hF};
  localparam rgb_t RGB_PLAYER = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t RGB_DOT    = '{r: 4'hF, g: 4'hB, b: 4'h9};

  // Body colour for each ghost index.
  function automatic rgb_t ghost_color(input logic [1:0] idx);
    case (idx)
      2'd0:    return '{r: 4'hF, g: 4'h0, b: 4'h0};
      2'd1:    return '{r: 4'hF, g: 4'hB, b: 4'hF};
      2'd2:    return '{r: 4'h0, g: 4'hF, b: 4'hF};
      default: return '{r: 4'hF, g: 4'hB, b: 4'h5};
    endcase
  endfunction

endpackage

// File: rtl/pixel_compositor_sprite_hit.sv
// Sprite bounding-box test and mask bit lookup for one pixel against one sprite.
module sprite_hit
  import pixel_compositor_pkg::*;
#(
  parameter int unsigned TILE = tile_size
) (
  input  logic [COORD_W-1:0]   px,
  input  logic [COORD_W-1:0]   py,
  input  logic [COORD_W-1:0]   sx,
  input  logic [COORD_W-1:0]   sy,
  input  logic [TILE*TILE-1:0] mask,
  output logic                 hit_c,
  output logic                 bit_c
);

  localparam int unsigned IW = $clog2(TILE * TILE);

  logic [DIFF_W-1:0] dx;
  logic [DIFF_W-1:0] dy;
  logic [IW-1:0]     idx;

  // Widened differences: a pixel left of / above the sprite never wraps into range.
  assign dx    = {1'b0, px} - {1'b0, sx};
  assign dy    = {1'b0, py} - {1'b0, sy};
  assign hit_c = (dx < DIFF_W'(TILE)) && (dy < DIFF_W'(TILE));
  assign idx   = IW'(dy) * IW'(TILE) + IW'(dx);
  assign bit_c = mask[idx];

endmodule

// File: rtl/pixel_compositor.sv
// Three-stage per-pixel renderer: tile fetch, sprite/mask lookup, priority mux.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int unsigned TILE        = tile_size,
  parameter int unsigned MAP_W       = 28,
  parameter int unsigned MAP_H       = 31,
  parameter int unsigned NUM_GHOSTS  = 4,
  parameter int unsigned ANIM_PERIOD = 8,
  parameter int unsigned CONG_X      = 192,
  parameter int unsigned CONG_Y      = 224
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [9:0]                      pixel_x,
  input  logic [9:0]                      pixel_y,
  input  logic                            video_on,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            frame_start,
  output logic [9:0]                      tile_addr,
  input  logic [1:0]                      tile_type,
  input  logic [9:0]                      player_x,
  input  logic [9:0]                      player_y,
  input  logic [10*NUM_GHOSTS-1:0]        ghost_x,
  input  logic [10*NUM_GHOSTS-1:0]        ghost_y,
  input  logic [2*NUM_GHOSTS-1:0]         ghost_dir,
  input  logic                            game_won,
  input  logic [4*TILE*TILE-1:0]          background_r,
  input  logic [4*TILE*TILE-1:0]          background_g,
  input  logic [4*TILE*TILE-1:0]          background_b,
  input  logic [4*TILE*TILE-1:0]          wall_r,
  input  logic [4*TILE*TILE-1:0]          wall_g,
  input  logic [4*TILE*TILE-1:0]          wall_b,
  input  logic [TILE*TILE-1:0]            player_mask_f1,
  input  logic [TILE*TILE-1:0]            player_mask_f2,
  input  logic [TILE*TILE-1:0]            ghost_mask_f1,
  input  logic [TILE*TILE-1:0]            ghost_mask_f2,
  input  logic [TILE*TILE-1:0]            dot_mask,
  input  logic [TILE*TILE-1:0]            big_dot_mask,
  input  logic [4*TILE*TILE-1:0]          ghost_sclera_mask_up,
  input  logic [4*TILE*TILE-1:0]          ghost_sclera_mask_down,
  input  logic [4*TILE*TILE-1:0]          ghost_sclera_mask_left,
  input  logic [4*TILE*TILE-1:0]          ghost_sclera_mask_right,
  input  logic [4*TILE*TILE-1:0]          ghost_eye_mask_up,
  input  logic [4*TILE*TILE-1:0]          ghost_eye_mask_down,
  input  logic [4*TILE*TILE-1:0]          ghost_eye_mask_left,
  input  logic [4*TILE*TILE-1:0]          ghost_eye_mask_right,
  input  logic [CONGRATULATIONS_MASK_WIDTH*CONGRATULATIONS_MASK_HEIGHT-1:0] congratulations_mask,
  output logic [3:0]                      vga_r,
  output logic [3:0]                      vga_g,
  output logic [3:0]                      vga_b,
  output logic                            hsync_out,
  output logic                            vsync_out
);

  // TILE is a power of two: tile row/column come straight from the low pixel bits.
  localparam int unsigned TW   = $clog2(TILE);
  localparam int unsigned NPIX = TILE * TILE;
  localparam int unsigned PW   = $clog2(NPIX);
  localparam int unsigned CW   = CONGRATULATIONS_MASK_WIDTH;
  localparam int unsigned CH   = CONGRATULATIONS_MASK_HEIGHT;
  localparam int unsigned CIW  = $clog2(CW * CH);
  localparam int unsigned AW   = $clog2(ANIM_PERIOD);

  logic [COORD_W-1:0] s0_x, s0_y;
  logic               s0_valid, s0_vid, s0_off, s0_hs, s0_vs;
  logic               off_map_c;

  logic [AW-1:0]      anim_cnt;
  logic               anim_sel;

  logic               s1_valid, s1_vid, s1_off, s1_hs, s1_vs;
  logic               s1_cong, s1_eye, s1_scl, s1_body, s1_player, s1_dot;
  rgb_t               s1_body_rgb, s1_tile_rgb;

  rgb_t               rgb_next_c;

  assign off_map_c = (pixel_x >= COORD_W'(MAP_W * TILE)) || (pixel_y >= COORD_W'(MAP_H * TILE));

  // Stage 0: register pixel context and issue the maze RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_x      <= '0;
      s0_y      <= '0;
      s0_vid    <= 1'b0;
      s0_off    <= 1'b0;
      s0_hs     <= 1'b1;
      s0_vs     <= 1'b1;
      tile_addr <= '0;
    end else begin
      s0_valid  <= 1'b1;
      s0_x      <= pixel_x;
      s0_y      <= pixel_y;
      s0_vid    <= video_on;
      s0_off    <= off_map_c;
      s0_hs     <= hsync_in;
      s0_vs     <= vsync_in;
      tile_addr <= off_map_c ? '0
                 : COORD_W'(pixel_y[COORD_W-1:TW]) * COORD_W'(MAP_W) + COORD_W'(pixel_x[COORD_W-1:TW]);
    end
  end

  // Two-frame animation phase, advanced only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_cnt <= '0;
      anim_sel <= 1'b0;
    end else if (frame_start) begin
      if (anim_cnt == AW'(ANIM_PERIOD - 1)) begin
        anim_cnt <= '0;
        anim_sel <= ~anim_sel;
      end else begin
        anim_cnt <= anim_cnt + AW'(1);
      end
    end
  end

  // ---------------- Stage 1: sprite and mask lookup ----------------
  logic [PW-1:0]   pidx_c;
  logic [NPIX-1:0] player_mask_c, ghost_mask_c;
  logic            player_hit_c, player_bit_c;
  logic [NUM_GHOSTS-1:0] body_on_c, scl_on_c, eye_on_c;

  assign pidx_c        = {s0_y[TW-1:0], s0_x[TW-1:0]};
  assign player_mask_c = anim_sel ? player_mask_f2 : player_mask_f1;
  assign ghost_mask_c  = anim_sel ? ghost_mask_f2  : ghost_mask_f1;

  sprite_hit #(.TILE(TILE)) u_player (
    .px(s0_x), .py(s0_y), .sx(player_x), .sy(player_y),
    .mask(player_mask_c), .hit_c(player_hit_c), .bit_c(player_bit_c)
  );

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    logic [NPIX-1:0] scl_m, eye_m;
    logic            body_hit, body_bit, scl_hit, scl_bit, eye_hit, eye_bit;

    // Pick the sclera/eye artwork facing this ghost's direction.
    always_comb begin
      scl_m = ghost_sclera_mask_up[NPIX-1:0];
      eye_m = ghost_eye_mask_up[NPIX-1:0];
      case (dir_e'(ghost_dir[2*g +: 2]))
        DIR_DOWN: begin
          scl_m = ghost_sclera_mask_down[NPIX-1:0];
          eye_m = ghost_eye_mask_down[NPIX-1:0];
        end
        DIR_LEFT: begin
          scl_m = ghost_sclera_mask_left[NPIX-1:0];
          eye_m = ghost_eye_mask_left[NPIX-1:0];
        end
        DIR_RIGHT: begin
          scl_m = ghost_sclera_mask_right[NPIX-1:0];
          eye_m = ghost_eye_mask_right[NPIX-1:0];
        end
        default: ;
      endcase
    end

    sprite_hit #(.TILE(TILE)) u_body (
      .px(s0_x), .py(s0_y), .sx(ghost_x[10*g +: 10]), .sy(ghost_y[10*g +: 10]),
      .mask(ghost_mask_c), .hit_c(body_hit), .bit_c(body_bit)
    );
    sprite_hit #(.TILE(TILE)) u_sclera (
      .px(s0_x), .py(s0_y), .sx(ghost_x[10*g +: 10]), .sy(ghost_y[10*g +: 10]),
      .mask(scl_m), .hit_c(scl_hit), .bit_c(scl_bit)
    );
    sprite_hit #(.TILE(TILE)) u_eye (
      .px(s0_x), .py(s0_y), .sx(ghost_x[10*g +: 10]), .sy(ghost_y[10*g +: 10]),
      .mask(eye_m), .hit_c(eye_hit), .bit_c(eye_bit)
    );

    assign body_on_c[g] = body_hit & body_bit;
    assign scl_on_c[g]  = scl_hit & scl_bit;
    assign eye_on_c[g]  = eye_hit & eye_bit;
  end

  // Direction masks carry artwork only in their low NPIX bits.
  logic unused_mask_hi;
  assign unused_mask_hi = ^{ghost_sclera_mask_up[4*NPIX-1:NPIX], ghost_sclera_mask_down[4*NPIX-1:NPIX],
                            ghost_sclera_mask_left[4*NPIX-1:NPIX], ghost_sclera_mask_right[4*NPIX-1:NPIX],
                            ghost_eye_mask_up[4*NPIX-1:NPIX], ghost_eye_mask_down[4*NPIX-1:NPIX],
                            ghost_eye_mask_left[4*NPIX-1:NPIX], ghost_eye_mask_right[4*NPIX-1:NPIX]};

  logic [DIFF_W-1:0] cdx_c, cdy_c;
  logic [CIW-1:0]    cidx_c;
  logic              cong_c;

  assign cdx_c  = {1'b0, s0_x} - DIFF_W'(CONG_X);
  assign cdy_c  = {1'b0, s0_y} - DIFF_W'(CONG_Y);
  assign cidx_c = CIW'(cdy_c) * CIW'(CW) + CIW'(cdx_c);
  assign cong_c = game_won && (cdx_c < DIFF_W'(CW)) && (cdy_c < DIFF_W'(CH))
                  && congratulations_mask[cidx_c];

  rgb_t tile_rgb_c, body_rgb_c;
  logic dot_c, body_c;

  // Tile colour/dot from the returned tile type; lowest-index ghost body wins.
  always_comb begin
    tile_rgb_c = '{r: background_r[{pidx_c, 2'b00} +: 4],
                   g: background_g[{pidx_c, 2'b00} +: 4],
                   b: background_b[{pidx_c, 2'b00} +: 4]};
    dot_c      = 1'b0;
    case (tile_type_e'(tile_type))
      TILE_WALL:    tile_rgb_c = '{r: wall_r[{pidx_c, 2'b00} +: 4],
                                   g: wall_g[{pidx_c, 2'b00} +: 4],
                                   b: wall_b[{pidx_c, 2'b00} +: 4]};
      TILE_DOT:     dot_c = dot_mask[pidx_c];
      TILE_BIG_DOT: dot_c = big_dot_mask[pidx_c];
      default: ;
    endcase
    body_c     = 1'b0;
    body_rgb_c = RGB_BLACK;
    for (int i = int'(NUM_GHOSTS) - 1; i >= 0; i--) begin
      if (body_on_c[i]) begin
        body_c     = 1'b1;
        body_rgb_c = ghost_color(2'(i));
      end
    end
  end

  // Stage 1 register: layer flags and candidate colours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_vid      <= 1'b0;
      s1_off      <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_cong     <= 1'b0;
      s1_eye      <= 1'b0;
      s1_scl      <= 1'b0;
      s1_body     <= 1'b0;
      s1_player   <= 1'b0;
      s1_dot      <= 1'b0;
      s1_body_rgb <= RGB_BLACK;
      s1_tile_rgb <= RGB_BLACK;
    end else begin
      s1_valid    <= s0_valid;
      s1_vid      <= s0_vid;
      s1_off      <= s0_off;
      s1_hs       <= s0_hs;
      s1_vs       <= s0_vs;
      s1_cong     <= cong_c;
      s1_eye      <= |eye_on_c;
      s1_scl      <= |scl_on_c;
      s1_body     <= body_c;
      s1_player   <= player_hit_c & player_bit_c;
      s1_dot      <= dot_c;
      s1_body_rgb <= body_rgb_c;
      s1_tile_rgb <= tile_rgb_c;
    end
  end

  // Stage 2 priority: overlay, eye, sclera, ghost, player, dot, tile.
  always_comb begin
    rgb_next_c = RGB_BLACK;
    if (s1_valid && s1_vid) begin
      if (s1_cong)         rgb_next_c = RGB_WHITE;
      else if (s1_off)     rgb_next_c = RGB_BLACK;
      else if (s1_eye)     rgb_next_c = RGB_EYE;
      else if (s1_scl)     rgb_next_c = RGB_WHITE;
      else if (s1_body)    rgb_next_c = s1_body_rgb;
      else if (s1_player)  rgb_next_c = RGB_PLAYER;
      else if (s1_dot)     rgb_next_c = RGB_DOT;
      else                 rgb_next_c = s1_tile_rgb;
    end
  end

  // Output register with syncs aligned to the pixel colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vga_r     <= rgb_next_c.r;
      vga_g     <= rgb_next_c.g;
      vga_b     <= rgb_next_c.b;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Per-pixel renderer between the VGA timing generator and the DAC pins.
- Consumes the sprite masks and tile colours produced by the image-loading block, plus the maze tile RAM read port and the game-state positions.
- Outputs a registered 12-bit RGB stream with the sync signals delayed to match.
- Owns the two-frame sprite animation counter.

Parameters:
- TILE, 16, tile edge in pixels (equals `tile_size).
- MAP_W, 28, maze width in tiles.
- MAP_H, 31, maze height in tiles.
- NUM_GHOSTS, 4, number of ghost sprites.
- ANIM_PERIOD, 8, frames per animation phase.
- CONG_X, 192, congratulations overlay left edge in pixels.
- CONG_Y, 224, congratulations overlay top edge in pixels.

Ports:
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- pixel_x, in, 10, current pixel column.
- pixel_y, in, 10, current pixel row.
- video_on, in, 1, visible-area flag.
- hsync_in, in, 1, horizontal sync from the timing generator.
- vsync_in, in, 1, vertical sync from the timing generator.
- frame_start, in, 1, one-cycle pulse at frame start.
- tile_addr, out, 10, maze RAM read address.
- tile_type, in, 2, maze RAM data, valid 1 cycle after the address. Codes: 0 empty, 1 wall, 2 dot, 3 big dot.
- player_x, in, 10, player sprite top-left x in pixels.
- player_y, in, 10, player sprite top-left y in pixels.
- ghost_x, in, 10*NUM_GHOSTS, packed ghost x positions.
- ghost_y, in, 10*NUM_GHOSTS, packed ghost y positions.
- ghost_dir, in, 2*NUM_GHOSTS, ghost direction. Codes: 0 up, 1 down, 2 left, 3 right.
- game_won, in, 1, enables the congratulations overlay.
- background_r/g/b, in, 4*TILE*TILE each, background tile colours.
- wall_r/g/b, in, 4*TILE*TILE each, wall tile colours.
- player_mask_f1, player_mask_f2, in, TILE*TILE, player animation frames.
- ghost_mask_f1, ghost_mask_f2, in, TILE*TILE, ghost body animation frames.
- dot_mask, big_dot_mask, in, TILE*TILE, dot sprites.
- ghost_sclera_mask_up/down/left/right, in, 4*TILE*TILE, only the low TILE*TILE bits are meaningful.
- ghost_eye_mask_up/down/left/right, in, 4*TILE*TILE, only the low TILE*TILE bits are meaningful.
- congratulations_mask, in, CW*CH, overlay mask.
- vga_r, out, 4, red output.
- vga_g, out, 4, green output.
- vga_b, out, 4, blue output.
- hsync_out, out, 1, delayed horizontal sync.
- vsync_out, out, 1, delayed vertical sync.

Behaviour:
- Reset values: vga_r/g/b 0, hsync_out/vsync_out 1, tile_addr 0, anim_sel 0, anim_cnt 0, all pipeline valid bits 0.
- Mask addressing: the bit for pixel (row r, col c) within a tile is [r*TILE+c]. Colour nibble index is [(r*TILE+c)*4 +: 4].
- Stage 0:
  - Register x, y, video_on and syncs.
  - Drive tile_addr = (y/TILE)*MAP_W + x/TILE.
  - If the pixel lies outside MAP_W*TILE by MAP_H*TILE, flag off_map and drive tile_addr 0.
- Stage 1:
  - Capture tile_type.
  - Compute sprite hits. A sprite is hit when 0 <= px-sx < TILE and 0 <= py-sy < TILE, using unsigned compare on 11-bit differences so that negative results fail.
  - Look up mask bits using the current anim_sel: 0 selects f1, 1 selects f2.
  - Select the sclera/eye masks by ghost_dir.
- Stage 2: registered priority mux, highest first:
  1. Congratulations: game_won and the pixel is inside the CW by CH box at CONG_X/CONG_Y and the mask bit is 1 -> F/F/F.
  2. Ghost eye -> 2/2/F.
  3. Ghost sclera -> F/F/F.
  4. Ghost body -> GHOST_COLOR[i]. The lowest index wins among ghosts.
  5. Player -> F/F/0.
  6. Dot tile with dot_mask set, or big-dot tile with big_dot_mask set -> F/B/9.
  7. Wall tile -> wall colour nibble.
  8. Otherwise -> background colour nibble.
- Blanking: video_on=0 or off_map forces 0/0/0. Off-map pixels still show the congratulations overlay.
- Latency: exactly 3 clocks from pixel input to vga_* output. hsync and vsync are delayed by the same 3 clocks.
- Animation:
  - On a frame_start pulse, anim_cnt increments.
  - When anim_cnt is ANIM_PERIOD-1 on the pulse, anim_cnt wraps to 0 and anim_sel toggles.
  - anim_sel changes only on frame_start, never mid-frame.
- Position inputs are sampled at stage 1 with no internal latching. Upstream holds positions stable during the visible area.
- An asynchronous reset mid-frame clears the pipeline immediately. Output is black with syncs high until 3 valid cycles have passed after release.

Decomposition:
- Shared package/define file holds:
  - tile_size, CONGRATULATIONS_MASK_WIDTH/HEIGHT.
  - Tile-type codes and direction codes.
  - GHOST_COLOR table: 0 F/0/0, 1 F/B/F, 2 0/F/F, 3 F/B/5.
  - Fixed palette constants.
- One sub-module, sprite_hit: takes the pixel position, sprite position and mask; outputs the hit and mask bit. Instantiated once for the player and NUM_GHOSTS times for ghost body, sclera and eye.

Test Plan:
- Reset release, wall tile at (0,0), pixel (3,5), video_on=1 -> 3 cycles later RGB = wall_r/g/b nibble at index 5*16+3. Before that the output is 0/0/0.
- Player at (32,32), pixel (40,40), player_mask_f1 bit 136 = 1, anim_sel=0 -> F/F/0. After 8 frame_start pulses with bit 136 of f2 = 0 -> tile colour.
- Ghost 0 and the player both at (64,64), ghost_dir=2, eye_left bit set at (r2,c3) -> pixel (67,66) is 2/2/F. An adjacent body-only pixel is F/0/0.
- Ghosts 1 and 2 overlap at (100,100) -> body pixel shows F/B/F.
- game_won=1, pixel (CONG_X,CONG_Y) with mask bit 0 set -> F/F/F. With game_won=0 -> tile colour.
- video_on=0 at any pixel -> 0/0/0. hsync_in toggled at cycle t -> hsync_out toggles at cycle t+3. Ghost at x=1020 with pixel x=2 -> no hit, because there is no wrap-around.
